// File: rtl/rca_multiword_seq.sv
// Multi-word add/subtract sequencer: one SIZE-bit ripple-carry adder is
// reused over WORDS chunks, least-significant chunk first, with the carry
// between chunks held in a register.

// SIZE-bit ripple-carry adder, purely combinational.
module parametric_RCA #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] i_x,
  input  logic [SIZE-1:0] i_y,
  input  logic            i_cin,
  output logic [SIZE-1:0] o_sum,
  output logic            o_cout
);
  logic [SIZE:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    assign o_sum[i]  = i_x[i] ^ i_y[i] ^ w_c[i];
    assign w_c[i+1]  = (i_x[i] & i_y[i]) | (w_c[i] & (i_x[i] ^ i_y[i]));
  end

  assign o_cout = w_c[SIZE];
endmodule

module rca_multiword_seq #(
  parameter int SIZE  = 8,
  parameter int WORDS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_sub,
  input  logic [SIZE*WORDS-1:0] i_a,
  input  logic [SIZE*WORDS-1:0] i_b,
  input  logic                  i_cin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [SIZE*WORDS-1:0] o_result,
  output logic                  o_cout,
  output logic                  o_ovf
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                       r_state, w_state_nxt;
  logic [WORDS-1:0][SIZE-1:0]   r_a, r_b, r_res;
  logic [IW-1:0]                r_idx;
  logic                         r_carry, r_done, r_cout, r_ovf;

  logic [SIZE-1:0]              w_x, w_y, w_sum;
  logic                         w_cout, w_accept, w_last;

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_last   = (r_state == S_RUN) && (r_idx == IW'(WORDS - 1));

  // Select the current chunk of each operand register.
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (r_idx == IW'(k)) begin
        w_x = r_a[k];
        w_y = r_b[k];
      end
    end
  end

  parametric_RCA #(.SIZE(SIZE)) u_rca (
    .i_x    (w_x),
    .i_y    (w_y),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: leave IDLE on start, return after the top chunk.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then one chunk per RUN cycle.
  // Subtraction is a + ~b + 1, so B is inverted at capture and the carry
  // seeded with 1; the overflow test then uses the inverted top bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= i_a;
        r_b     <= i_sub ? ~i_b : i_b;
        r_carry <= i_sub ? 1'b1 : i_cin;
        r_idx   <= '0;
      end else if (r_state == S_RUN) begin
        for (int k = 0; k < WORDS; k++)
          if (r_idx == IW'(k)) r_res[k] <= w_sum;
        r_carry <= w_cout;
        r_idx   <= w_last ? '0 : r_idx + IW'(1);
        if (w_last) begin
          r_cout <= w_cout;
          r_ovf  <= (w_x[SIZE-1] ~^ w_y[SIZE-1]) & (w_sum[SIZE-1] ^ w_x[SIZE-1]);
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy   = (r_state == S_RUN);
  assign o_done   = r_done;
  assign o_result = r_res;
  assign o_cout   = r_cout;
  assign o_ovf    = r_ovf;
endmodule

// File: tb/tb_rca_multiword_seq.sv
// Bench for rca_multiword_seq: a 4-word instance checked every cycle against
// a whole-width arithmetic model, plus a 1-word instance with literal checks.
module tb_rca_multiword_seq;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // 4-word DUT
  logic          d4_start = 0, d4_sub = 0, d4_cin = 0;
  logic [N-1:0]  d4_a = '0, d4_b = '0;
  logic          d4_busy, d4_done, d4_cout, d4_ovf;
  logic [N-1:0]  d4_result;

  rca_multiword_seq #(.SIZE(8), .WORDS(4)) u_d4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(d4_start), .i_sub(d4_sub),
    .i_a(d4_a), .i_b(d4_b), .i_cin(d4_cin),
    .o_busy(d4_busy), .o_done(d4_done), .o_result(d4_result),
    .o_cout(d4_cout), .o_ovf(d4_ovf)
  );

  // 1-word DUT
  logic          d1_start = 0, d1_sub = 0, d1_cin = 0;
  logic [7:0]    d1_a = '0, d1_b = '0;
  logic          d1_busy, d1_done, d1_cout, d1_ovf;
  logic [7:0]    d1_result;

  rca_multiword_seq #(.SIZE(8), .WORDS(1)) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(d1_start), .i_sub(d1_sub),
    .i_a(d1_a), .i_b(d1_b), .i_cin(d1_cin),
    .o_busy(d1_busy), .o_done(d1_done), .o_result(d1_result),
    .o_cout(d1_cout), .o_ovf(d1_ovf)
  );

  // Model of the 4-word DUT: full-width arithmetic computed at acceptance,
  // published after a WORDS-cycle countdown.
  logic          m_busy = 0, m_done = 0, m_cout = 0, m_ovf = 0;
  logic [N-1:0]  m_res = '0;
  int            m_cnt = 0;
  logic [N-1:0]  p_res;
  logic          p_cout, p_ovf;

  always @(posedge clk or negedge rst_n) begin
    logic [N:0]   t;
    logic [N-1:0] bb;
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_cnt = 0; m_res = '0; m_cout = 0; m_ovf = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; m_done = 1;
          m_res = p_res; m_cout = p_cout; m_ovf = p_ovf;
        end
      end else if (d4_start) begin
        bb = d4_sub ? ~d4_b : d4_b;
        t  = {1'b0, d4_a} + {1'b0, bb} + {{N{1'b0}}, (d4_sub ? 1'b1 : d4_cin)};
        p_res  = t[N-1:0];
        p_cout = t[N];
        p_ovf  = (d4_a[N-1] == bb[N-1]) && (t[N-1] != d4_a[N-1]);
        m_busy = 1;
        m_cnt  = 4;
      end
    end
  end

  // Every-cycle comparison; result/flags only meaningful outside RUN.
  always @(negedge clk) begin
    chk("busy", {63'd0, d4_busy}, {63'd0, m_busy});
    chk("done", {63'd0, d4_done}, {63'd0, m_done});
    if (!m_busy) begin
      chk("result", {32'd0, d4_result}, {32'd0, m_res});
      chk("cout", {63'd0, d4_cout}, {63'd0, m_cout});
      chk("ovf", {63'd0, d4_ovf}, {63'd0, m_ovf});
    end
  end

  task automatic issue4(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input logic c);
    @(posedge clk); #1;
    d4_a = a; d4_b = b; d4_sub = s; d4_cin = c; d4_start = 1;
    @(posedge clk); #1;
    d4_start = 0;
  endtask

  task automatic wait4(output int busy_cyc);
    bit ok = 0;
    busy_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d4_done) begin ok = 1; break; end
      if (d4_busy) busy_cyc++;
    end
    if (!ok) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic lit4(input string nm, input logic [N-1:0] r, input logic c, input logic o);
    chk({nm, "_res"}, {32'd0, d4_result}, {32'd0, r});
    chk({nm, "_cout"}, {63'd0, d4_cout}, {63'd0, c});
    chk({nm, "_ovf"}, {63'd0, d4_ovf}, {63'd0, o});
  endtask

  task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] r, input logic co);
    @(posedge clk); #1;
    d1_a = a; d1_b = b; d1_sub = 0; d1_cin = c; d1_start = 1;
    @(posedge clk); #1;
    d1_start = 0;
    @(negedge clk);
    chk("w1_busy", {63'd0, d1_busy}, 64'd1);
    @(negedge clk);
    chk("w1_done", {63'd0, d1_done}, 64'd1);
    chk("w1_res", {56'd0, d1_result}, {56'd0, r});
    chk("w1_cout", {63'd0, d1_cout}, {63'd0, co});
    chk("w1_ovf", {63'd0, d1_ovf}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int ndone;
    // Reset state
    #12;
    chk("rst_busy", {63'd0, d4_busy}, 64'd0);
    chk("rst_done", {63'd0, d4_done}, 64'd0);
    chk("rst_res", {32'd0, d4_result}, 64'd0);
    chk("rst_w1_res", {56'd0, d1_result}, 64'd0);
    rst_n = 1;

    issue4(32'h12345678, 32'h11111111, 0, 0);
    wait4(bc);
    chk("busy_cycles", bc, 4);
    lit4("add1", 32'h23456789, 0, 0);

    issue4(32'hFFFFFFFF, 32'h00000001, 0, 0);
    wait4(bc);
    lit4("ripple", 32'h00000000, 1, 0);

    issue4(32'h00000005, 32'h00000007, 1, 0);
    wait4(bc);
    lit4("sub_borrow", 32'hFFFFFFFE, 0, 0);

    issue4(32'h80000000, 32'h00000001, 1, 0);
    wait4(bc);
    lit4("sub_ovf", 32'h7FFFFFFF, 1, 1);

    issue4(32'h7FFFFFFF, 32'h00000001, 0, 0);
    wait4(bc);
    lit4("add_ovf", 32'h80000000, 0, 1);

    issue4(32'h000000FF, 32'h00000000, 0, 1);
    wait4(bc);
    lit4("add_cin", 32'h00000100, 0, 0);

    // Start during RUN is ignored; operand changes after accept ignored
    issue4(32'h00000010, 32'h00000020, 0, 0);
    @(posedge clk); #1;
    d4_a = 32'hAAAA0000; d4_b = 32'h5555; d4_sub = 1; d4_start = 1;
    @(posedge clk); #1;
    d4_start = 0;
    wait4(bc);
    lit4("ignored", 32'h00000030, 0, 0);

    // Start held across done: accepted in the done cycle
    @(posedge clk); #1;
    d4_a = 32'h00010000; d4_b = 32'h00020000; d4_sub = 0; d4_cin = 0; d4_start = 1;
    @(posedge clk); #1;
    wait4(bc);
    lit4("held1", 32'h00030000, 0, 0);
    d4_a = 32'h00000003; d4_b = 32'h00000004; d4_cin = 1;
    @(posedge clk); #1;
    d4_start = 0;
    @(negedge clk);
    chk("held_busy", {63'd0, d4_busy}, 64'd1);
    chk("held_done", {63'd0, d4_done}, 64'd0);
    wait4(bc);
    lit4("held2", 32'h00000008, 0, 0);

    // Reset during the 3rd RUN cycle
    issue4(32'h12345678, 32'h11111111, 0, 0);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("abort_busy", {63'd0, d4_busy}, 64'd0);
    chk("abort_done", {63'd0, d4_done}, 64'd0);
    chk("abort_res", {32'd0, d4_result}, 64'd0);
    chk("abort_cout", {63'd0, d4_cout}, 64'd0);
    chk("abort_ovf", {63'd0, d4_ovf}, 64'd0);
    @(posedge clk); #2;
    rst_n = 1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (d4_done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    issue4(32'hFFFFFFFF, 32'h00000001, 0, 0);
    wait4(bc);
    lit4("post_rst", 32'h00000000, 1, 0);

    // 1-word instance
    op1(8'd217, 8'd65, 0, 8'h1A, 1);
    op1(8'd110, 8'd221, 1, 8'h4C, 1);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rca_multiword_seq.md
# rca_multiword_seq

Sequencer that performs wide add/subtract by time-multiplexing one `parametric_RCA` instance of width SIZE over WORDS chunks, least-significant chunk first. A registered carry links successive chunks. It sits between a requester issuing start/operands and the shared RCA datapath, and returns a WORDS*SIZE-bit result with carry-out and signed-overflow flags. A start/busy/done handshake frames each operation.

## Interface
- SIZE, 8, chunk width in bits; width of the internal `parametric_RCA` (SIZE ≥ 1).
- WORDS, 4, number of chunks per operand (WORDS ≥ 1); operand width N = SIZE*WORDS.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b+cin, 1 = a−b (cin ignored).
- a  input  N  operand A, captured at accepted start.
- b  input  N  operand B, captured at accepted start.
- cin  input  1  carry-in for add, captured at accepted start.
- busy  output  1  high while chunks are being processed.
- done  output  1  one-cycle pulse when result/flags become valid.
- result  output  N  sum/difference; held until next accepted start.
- cout  output  1  final carry-out; for sub, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow of the N-bit operation.

## Operation
- States: IDLE, RUN. Reset → IDLE; busy=0, done=0, result=0, cout=0, ovf=0, chunk index=0, carry reg=0, operand regs=0.
- IDLE: start=1 accepted → latch a into A reg; latch b (sub=0) or ~b (sub=1) into B reg; carry reg ← cin (sub=0) or 1 (sub=1); index ← 0; → RUN. start=0 → stay.
- RUN, every cycle: RCA x = A reg chunk[index], y = B reg chunk[index], cin = carry reg. On the edge: result chunk[index] ← RCA sum; carry reg ← RCA cout; index ← index+1.
- On the edge processing index = WORDS−1: cout ← RCA cout; ovf ← (x[SIZE−1] ~^ y[SIZE−1]) & (sum[SIZE−1] ^ x[SIZE−1]), using the post-inversion y; done ← 1; → IDLE; index ← 0.
- done is high exactly one cycle; cleared on the following edge.
- result chunks are overwritten in order during RUN; result is valid only from the done cycle onward. Intermediate values are visible but not guaranteed.
- start during RUN is ignored, not queued. start in the same cycle done is high is accepted, because the FSM is already IDLE.
- Operands changing after acceptance have no effect.
- Index register width is max(1, $clog2(WORDS)). WORDS=1 completes in one RUN cycle.
- Arithmetic is unsigned modulo 2^N; the carry out of the top chunk goes to cout, not to result.

## Timing
- Accept edge E0: busy=1 from E0 until edge E0+WORDS, where it falls.
- Chunk k is written at edge E0+1+k.
- done=1, result/cout/ovf valid in the cycle after edge E0+WORDS.
- Latency from start sampled to done: WORDS cycles. Throughput: one operation per WORDS+1 cycles, with start held high.
- The RCA path is purely combinational within one cycle: chunk operand reg → RCA → result/carry reg.
- rst_n low at any time, including mid-RUN, immediately forces every output and register to its reset value. No done is issued for the aborted operation. After rst_n rises, the first edge sees IDLE.

## Test plan
- SIZE=8, WORDS=4, add 0x12345678 + 0x11111111, cin=0 → after 4 cycles done=1, result=0x23456789, cout=0, ovf=0; busy high exactly 4 cycles.
- Add 0xFFFFFFFF + 0x00000001, cin=0 → result=0x00000000, cout=1, ovf=0. Exercises carry propagation through every chunk.
- sub=1, 0x00000005 − 0x00000007 → result=0xFFFFFFFE, cout=0 (borrow), ovf=0. Then 0x80000000 − 0x00000001 → result=0x7FFFFFFF, cout=1, ovf=1.
- Add 0x7FFFFFFF + 0x00000001 → result=0x80000000, ovf=1, cout=0. Then SIZE=8, WORDS=1 bench: 217+65, cin=0 → result=0x1A, cout=1; 110+221, cin=1 → result=0x4C, cout=1; each done after 1 cycle.
- Pulse start again at the 2nd RUN cycle with different operands → ignored; result equals the first operation. Start held high across done → next operation accepted in the done cycle, and busy rises the following cycle.
- Assert rst_n=0 during the 3rd RUN cycle → busy/done/result/cout/ovf=0 immediately; no done pulse. A fresh start after release completes normally with the correct result.
